// File: rtl/buff_inject_pkg.sv
// rtl/buff_inject_pkg.sv - shared router flit format and port indices
// Used by the eject stage and by buff_inject so both agree on the flit layout.
package buff_inject_pkg;

    localparam int FLIT_W = 11;

    // Flit field positions: [10:9] type, [8:6] destination, [5:0] payload.
    localparam int F_TYPE_HI = 10;
    localparam int F_TYPE_LO = 9;
    localparam int F_DEST_HI = 8;
    localparam int F_DEST_LO = 6;
    localparam int F_PAY_HI  = 5;
    localparam int F_PAY_LO  = 0;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        PORT_N = 2'd0,
        PORT_S = 2'd1,
        PORT_E = 2'd2,
        PORT_W = 2'd3
    } port_t;

    // Rotating-priority successor; wraps W back to N.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return p + 2'd1;
    endfunction

endpackage

// File: rtl/buff_inject_if.sv
// rtl/buff_inject_if.sv - side-buffer push handshake between eject stage and buff_inject
// Signals: sb_flit (flit), sb_valid (push request), sb_ready (buffer can accept).
// master: eject stage. slave: buff_inject.
interface buff_inject_if;
    import buff_inject_pkg::*;

    flit_t sb_flit;
    logic  sb_valid;
    logic  sb_ready;

    modport master (output sb_flit, output sb_valid, input sb_ready);
    modport slave  (input sb_flit, input sb_valid, output sb_ready);

endinterface

// File: rtl/buff_inject_sb_fifo.sv
// rtl/buff_inject_sb_fifo.sv - circular side-buffer FIFO used by buff_inject
// Ports: clk, rst_n (async active-low), push/push_data, pop, head (oldest entry),
//        full, empty, count (occupancy, $clog2(DEPTH)+1 bits).
module sb_fifo
    import buff_inject_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  flit_t                  push_data,
    input  logic                   pop,
    output flit_t                  head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    flit_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push while full is dropped even if a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head comes only from storage, so a freshly pushed flit is never bypassed.
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: clearing count discards all entries.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/buff_inject.sv
// rtl/buff_inject.sv - side buffer reinjection into free pipeline slots
// Ports: clk, rst_n (async active-low); sb (slave side of the push handshake);
//        northad/southad/eastad/westad + n/s/e/w_vin: slots after ejection;
//        nad/sad/ead/wad + n/s/e/w_vout: registered slots after reinjection;
//        sb_count: buffer occupancy; starve: head flit waited STARVE_LIMIT cycles.
module buff_inject
    import buff_inject_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    buff_inject_if.slave           sb,
    input  flit_t                  northad,
    input  flit_t                  southad,
    input  flit_t                  eastad,
    input  flit_t                  westad,
    input  logic                   n_vin,
    input  logic                   s_vin,
    input  logic                   e_vin,
    input  logic                   w_vin,
    output flit_t                  nad,
    output flit_t                  sad,
    output flit_t                  ead,
    output flit_t                  wad,
    output logic                   n_vout,
    output logic                   s_vout,
    output logic                   e_vout,
    output logic                   w_vout,
    output logic [$clog2(DEPTH):0] sb_count,
    output logic                   starve
);

    localparam int WW = $clog2(STARVE_LIMIT + 1);

    flit_t          head;
    logic           full;
    logic           empty;
    logic           inj;
    logic           found;
    logic [1:0]     sel;
    logic [1:0]     rr_ptr;
    logic [3:0]     vin;
    flit_t          din    [4];
    flit_t          slot_d [4];
    logic [3:0]     slot_v;
    logic [WW-1:0]  wait_cnt;
    logic [WW-1:0]  wait_nxt;

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (sb.sb_valid),
        .push_data (sb.sb_flit),
        .pop       (inj),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (sb_count)
    );

    assign sb.sb_ready = !full;

    assign vin          = {w_vin, e_vin, s_vin, n_vin};
    assign din[PORT_N]  = northad;
    assign din[PORT_S]  = southad;
    assign din[PORT_E]  = eastad;
    assign din[PORT_W]  = westad;

    // Rotating search starting at rr_ptr: first slot with no valid flit wins.
    always_comb begin
        logic [1:0] idx;
        sel   = rr_ptr;
        found = 1'b0;
        idx   = rr_ptr;
        for (int i = 0; i < 4; i++) begin
            if (!found && !vin[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = next_port(idx);
        end
    end

    assign inj = found && !empty;

    // Head wait counter: cleared on pop or while empty, saturating at the limit.
    always_comb begin
        wait_nxt = wait_cnt;
        if (empty || inj) begin
            wait_nxt = '0;
        end else if (wait_cnt != WW'(STARVE_LIMIT)) begin
            wait_nxt = wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            wait_cnt <= '0;
            starve   <= 1'b0;
            slot_v   <= '0;
            for (int i = 0; i < 4; i++) slot_d[i] <= '0;
        end else begin
            wait_cnt <= wait_nxt;
            starve   <= (wait_nxt == WW'(STARVE_LIMIT));
            if (inj) rr_ptr <= next_port(sel);
            for (int i = 0; i < 4; i++) begin
                if (inj && sel == 2'(i)) begin
                    slot_d[i] <= head;
                    slot_v[i] <= 1'b1;
                end else begin
                    // Empty slots carry a zero flit rather than stale data.
                    slot_d[i] <= vin[i] ? din[i] : '0;
                    slot_v[i] <= vin[i];
                end
            end
        end
    end

    assign nad    = slot_d[PORT_N];
    assign sad    = slot_d[PORT_S];
    assign ead    = slot_d[PORT_E];
    assign wad    = slot_d[PORT_W];
    assign n_vout = slot_v[PORT_N];
    assign s_vout = slot_v[PORT_S];
    assign e_vout = slot_v[PORT_E];
    assign w_vout = slot_v[PORT_W];

endmodule
